// File: rtl/write_buffer_pkg.sv
// Shared types and sizing for the write buffer between the write-through cache and main memory.
package write_buffer_pkg;

    localparam int unsigned ADDR_WIDTH = 10;
    localparam int unsigned WIDTH      = 32;
    localparam int unsigned DEPTH      = 4;
    localparam int unsigned PTR_WIDTH  = 2;
    localparam int unsigned CNT_WIDTH  = PTR_WIDTH + 1;

    localparam logic WB_IDLE  = 1'b0;
    localparam logic WB_WRITE = 1'b1;

    typedef enum logic {
        ST_IDLE  = WB_IDLE,
        ST_WRITE = WB_WRITE
    } wb_state_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [WIDTH-1:0]      data;
    } wb_entry_t;

    // Word offset within a 4-word block is ignored when matching blocks.
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ~(ADDR_WIDTH'(3));

    function automatic logic same_block(input logic [ADDR_WIDTH-1:0] a,
                                        input logic [ADDR_WIDTH-1:0] b);
        return ((a ^ b) & BLK_MASK) == '0;
    endfunction

endpackage

// File: rtl/write_buffer_fifo_mem.sv
// Entry storage for the write buffer: one write port, one read port, per-entry block compare.
module wb_fifo_mem
    import write_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  we,
    input  logic [PTR_WIDTH-1:0]  waddr,
    input  wb_entry_t             wentry,
    input  logic [PTR_WIDTH-1:0]  raddr,
    output wb_entry_t             rentry,
    input  logic [ADDR_WIDTH-1:0] cmp_addr,
    output logic [DEPTH-1:0]      match
);

    wb_entry_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wentry;
        end
    end

    assign rentry = mem[raddr];

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            match[i] = same_block(mem[i].addr, cmp_addr);
        end
    end

endmodule

// File: rtl/write_buffer.sv
// FIFO store buffer draining to main memory over mem_write/mem_ready.
// Optional WB_COALESCE_EN merges a repeated write to the newest entry's address.
module write_buffer
    import write_buffer_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enq_valid,
    input  logic [ADDR_WIDTH-1:0] enq_addr,
    input  logic [WIDTH-1:0]      enq_data,
    output logic                  full,
    output logic                  empty,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rd_conflict,
    output logic                  mem_write,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic                  mem_ready
);

    wb_state_e             state;
    logic [PTR_WIDTH-1:0]  head, tail, newest, wr_idx, raddr;
    logic [CNT_WIDTH-1:0]  count, count_next;
    logic [ADDR_WIDTH-1:0] newest_addr;
    logic                  push, pop, coalesce, mem_we;
    logic [DEPTH-1:0]      match, valid;
    wb_entry_t             wr_entry, rd_entry, load_entry;

    assign pop    = (state == ST_WRITE) && mem_ready;
    assign newest = tail - PTR_WIDTH'(1);

`ifdef WB_COALESCE_EN
    // Newest entry equals the head exactly when count is 1; never rewrite it mid-flight.
    assign coalesce = enq_valid && (count != '0) && (newest_addr == enq_addr)
                      && !((count == CNT_WIDTH'(1)) && (state == ST_WRITE));
`else
    assign coalesce = 1'b0;
`endif

    assign push     = enq_valid && !full && !coalesce;
    assign mem_we   = push || coalesce;
    assign wr_idx   = coalesce ? newest : tail;
    assign wr_entry = '{addr: enq_addr, data: enq_data};
    assign raddr    = pop ? (head + PTR_WIDTH'(1)) : head;

    // Entry being written this cycle is the one about to be presented: bypass the array.
    assign load_entry = (mem_we && (wr_idx == raddr)) ? wr_entry : rd_entry;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + CNT_WIDTH'(1);
        end else if (!push && pop) begin
            count_next = count - CNT_WIDTH'(1);
        end
    end

    always_comb begin
        valid = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            valid[i] = CNT_WIDTH'(PTR_WIDTH'(PTR_WIDTH'(i) - head)) < count;
        end
    end

    assign rd_conflict = |(match & valid);

    wb_fifo_mem u_mem (
        .clk      (clk),
        .we       (mem_we),
        .waddr    (wr_idx),
        .wentry   (wr_entry),
        .raddr    (raddr),
        .rentry   (rd_entry),
        .cmp_addr (rd_addr),
        .match    (match)
    );

    // Pointers, flags and drain FSM; WRITE always holds count >= 1, so empty tracks count_next.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            newest_addr <= '0;
            full        <= 1'b0;
            empty       <= 1'b1;
            mem_write   <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
        end else begin
            if (push) begin
                tail        <= tail + PTR_WIDTH'(1);
                newest_addr <= enq_addr;
            end
            if (pop) begin
                head <= head + PTR_WIDTH'(1);
            end
            count <= count_next;
            full  <= (count_next == CNT_WIDTH'(DEPTH));
            empty <= (count_next == '0);
            case (state)
                ST_IDLE: begin
                    if (count != '0) begin
                        state     <= ST_WRITE;
                        mem_write <= 1'b1;
                        mem_addr  <= load_entry.addr;
                        mem_wdata <= load_entry.data;
                    end
                end
                ST_WRITE: begin
                    if (pop) begin
                        if (count_next != '0) begin
                            mem_addr  <= load_entry.addr;
                            mem_wdata <= load_entry.data;
                        end else begin
                            state     <= ST_IDLE;
                            mem_write <= 1'b0;
                        end
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_write <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_write_buffer.sv
// Self-checking bench for write_buffer: directed scenarios plus random traffic against a queue model.
module tb_write_buffer;
    import write_buffer_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset, enq_valid, mem_ready;
    logic                  full, empty, rd_conflict, mem_write;
    logic [ADDR_WIDTH-1:0] enq_addr, rd_addr, mem_addr;
    logic [WIDTH-1:0]      enq_data, mem_wdata;

    int vectors = 0;
    int miscompares = 0;

    // Model: every valid entry in order, q[0] is the head; writing mirrors an outstanding mem_write.
    wb_entry_t q[$];
    bit        writing = 1'b0;
    bit        after_reset = 1'b0;

    always #5 clk = ~clk;

    write_buffer dut (
        .clk         (clk),
        .reset       (reset),
        .enq_valid   (enq_valid),
        .enq_addr    (enq_addr),
        .enq_data    (enq_data),
        .full        (full),
        .empty       (empty),
        .rd_addr     (rd_addr),
        .rd_conflict (rd_conflict),
        .mem_write   (mem_write),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ready   (mem_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit conflict_m(input logic [ADDR_WIDTH-1:0] a);
        foreach (q[i]) begin
            if (q[i].addr[ADDR_WIDTH-1:2] == a[ADDR_WIDTH-1:2]) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One clock: drive inputs, check outputs at negedge, advance the model, cross the edge.
    task automatic step(input bit rst, input bit ev, input logic [ADDR_WIDTH-1:0] ea,
                        input logic [WIDTH-1:0] ed, input bit mr, input logic [ADDR_WIDTH-1:0] ra);
        int        n;
        bit        pop;
        bit        coal;
        wb_entry_t e;
        reset     = rst;
        enq_valid = ev;
        enq_addr  = ea;
        enq_data  = ed;
        mem_ready = mr;
        rd_addr   = ra;
        @(negedge clk);
        chk("mem_write", 64'(mem_write), 64'(writing));
        chk("full", 64'(full), 64'(q.size() == DEPTH));
        chk("empty", 64'(empty), 64'(q.size() == 0 && !writing));
        chk("rd_conflict", 64'(rd_conflict), 64'(conflict_m(ra)));
        if (writing) begin
            chk("mem_addr", 64'(mem_addr), 64'(q[0].addr));
            chk("mem_wdata", 64'(mem_wdata), 64'(q[0].data));
        end else if (after_reset) begin
            chk("mem_addr_rst", 64'(mem_addr), 64'(0));
            chk("mem_wdata_rst", 64'(mem_wdata), 64'(0));
        end
        if (rst) begin
            q.delete();
            writing     = 1'b0;
            after_reset = 1'b1;
        end else begin
            n    = q.size();
            pop  = writing && mr;
            coal = 1'b0;
`ifdef WB_COALESCE_EN
            coal = ev && (n != 0) && (q[n-1].addr == ea) && !(n == 1 && writing);
`endif
            if (coal) begin
                e      = q[n-1];
                e.data = ed;
                q[n-1] = e;
            end else if (ev && n < DEPTH) begin
                e.addr = ea;
                e.data = ed;
                q.push_back(e);
            end
            if (pop) void'(q.pop_front());
            if (writing) writing = !pop || (q.size() != 0);
            else         writing = (n != 0);
            if (writing) after_reset = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; enq_valid = 1'b0; enq_addr = '0; enq_data = '0;
        mem_ready = 1'b0; rd_addr = '0;
        @(posedge clk);
        #1;
        after_reset = 1'b1;

        // Single write with memory always ready.
        step(0, 0, '0, '0, 1, '0);
        step(0, 1, 10'h014, 32'hDEADBEEF, 1, '0);
        repeat (4) step(0, 0, '0, '0, 1, '0);

        // Fill to full while memory stalls, a fifth write is ignored, then drain back-to-back.
        for (int i = 0; i < 5; i++) step(0, 1, ADDR_WIDTH'(32'h100 + i * 4), $urandom, 0, '0);
        step(0, 0, '0, '0, 0, '0);
        repeat (7) step(0, 0, '0, '0, 1, '0);

        // Read-miss conflict on a queued and then in-flight block.
        step(0, 1, 10'h01C, $urandom, 0, 10'h01D);
        repeat (3) step(0, 0, '0, '0, 0, 10'h01D);
        step(0, 0, '0, '0, 1, 10'h01D);
        repeat (2) step(0, 0, '0, '0, 0, 10'h01D);

        // Enqueue coinciding with a pop on a full buffer is dropped.
        for (int i = 0; i < 4; i++) step(0, 1, ADDR_WIDTH'(32'h200 + i * 4), $urandom, 0, '0);
        step(0, 1, 10'h240, $urandom, 1, '0);
        chk("full_pop_count", 64'(dut.count), 64'(3));
        repeat (5) step(0, 0, '0, '0, 1, '0);

        // Reset in the middle of a drain discards everything.
        for (int i = 0; i < 3; i++) step(0, 1, ADDR_WIDTH'(32'h300 + i * 4), $urandom, 0, '0);
        step(0, 0, '0, '0, 0, '0);
        step(1, 0, '0, '0, 0, '0);
        repeat (4) step(0, 0, '0, '0, 1, '0);

`ifdef WB_COALESCE_EN
        // Repeated address behind a busy head merges into one entry.
        step(0, 1, 10'h010, 32'h0000_00AA, 0, '0);
        step(0, 1, 10'h020, 32'h0000_0001, 0, '0);
        step(0, 1, 10'h020, 32'h0000_0002, 0, '0);
        chk("coalesce_count", 64'(dut.count), 64'(2));
        repeat (5) step(0, 0, '0, '0, 1, '0);
`endif

        // Random traffic over a few blocks so conflicts, full stalls and merges all occur.
        repeat (400) begin
            step(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0),
                 ADDR_WIDTH'($urandom_range(8, 15)), $urandom,
                 ($urandom_range(0, 1) == 1), ADDR_WIDTH'($urandom_range(4, 19)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
